tmr_lane_scrubber: RTL and testbench
====================================

# tmr_lane_scrubber

Periodic scrubbing scheduler for a triplicated LANES-wide buffer array. It snapshots the three replica buses and walks the lanes one per cycle. For each lane whose replicas disagree, it issues a refresh request carrying the majority value over a valid/ready handshake, and it keeps a saturating count of mismatches. It sits beside the triplicated buffer bank and drives that bank's refresh path.

## Interface
- LANES, 6, number of buffer lanes (≥2)
- INTERVAL, 16, idle cycles between sweeps (≥1)
- CNT_W, 8, error counter width
- clk  in  1  clock, all state on rising edge
- rstn  in  1  reset, synchronous, active-low
- en  in  1  scrubbing enable
- clr_cnt  in  1  synchronous clear of err_cnt
- in_a, in_b, in_c  in  LANES  the three replica buses
- fix_valid  out  1  refresh request valid
- fix_ready  in  1  refresh request accepted
- fix_lane  out  $clog2(LANES)  lane index to refresh
- fix_value  out  1  majority value for fix_lane
- sweep_done  out  1  one-cycle pulse after the last lane is processed
- busy  out  1  high in SNAP, SCAN or REPORT
- err_cnt  out  CNT_W  saturating mismatch count

## Operation
- Reset (rstn=0 at an edge) sets state IDLE and clears every output (fix_valid=0, fix_lane=0, fix_value=0, sweep_done=0, busy=0, err_cnt=0), the snapshot, lane index and wait counter. Reset mid-REPORT drops the request with no handshake.
- FSM states and transitions:
  - IDLE: when en=1, go to SNAP.
  - SNAP: capture in_a/b/c into the snapshot, set lane=0, go to SCAN.
  - SCAN: evaluate snapshot lane `lane`.
    - Mismatch means the three bits are not all equal. The majority bit is (a&b)|(a&c)|(b&c).
    - On mismatch: load fix_lane/fix_value, assert fix_valid, go to REPORT.
    - On match at lane<LANES-1: lane+1, stay in SCAN.
    - On match at lane=LANES-1: pulse sweep_done, go to WAIT.
  - REPORT: hold fix_valid, fix_lane and fix_value stable until fix_valid&fix_ready at an edge.
    - On acceptance: drop fix_valid and increment err_cnt.
    - If lane<LANES-1: lane+1, back to SCAN.
    - Otherwise: pulse sweep_done, go to WAIT.
  - WAIT: load the counter with INTERVAL-1 on entry and decrement each cycle.
    - At 0 with en=1: go to SNAP.
    - At 0 with en=0: go to IDLE.
- en=0 in SCAN returns to IDLE on the next edge with no sweep_done pulse. en=0 in REPORT has no effect until the handshake completes, after which the block goes to IDLE. en=0 in WAIT is checked only at expiry.
- err_cnt saturates at 2^CNT_W-1. clr_cnt coincident with an increment clears the count and drops the increment. clr_cnt is honoured in every state.
- Inputs are sampled only in SNAP. Changes to in_a/b/c during a sweep are not seen until the next sweep.
- The block itself is triplicated by the TMR flow (module default: triplicate). It contains no do_not_triplicate nets.

## Timing
- Sweep with no mismatches: SNAP plus LANES cycles of SCAN. sweep_done is asserted in the cycle after the last SCAN cycle.
- Each mismatch adds 1 cycle (entry into REPORT) plus the ready-wait cycles. When fix_ready is held high, each mismatch costs exactly 1 extra cycle.
- Period between SNAP entries with en held high and no mismatches: 1+LANES+INTERVAL cycles (23 with the defaults).
- fix_valid rises the cycle after the SCAN evaluation. err_cnt updates the cycle after acceptance.
- Handshake rules: fix_valid never drops without acceptance, except on reset. fix_ready may be high before fix_valid.

## Structure
- Shared package tmr_scrub_pkg holds:
  - the state enum (IDLE, SNAP, SCAN, REPORT, WAIT);
  - the lane-index width function;
  - a maj3 function.
- One sub-module: tmr_scrub_wait_cnt, the WAIT down-counter with load and zero flag. Everything else is a single FSM process plus the snapshot registers.

## Test plan
- Reset, then en=1 with identical replicas 6'h2A: sweep_done pulses every 23 cycles, fix_valid never rises, err_cnt stays 0.
- in_a=6'h00, in_b=6'h00, in_c=6'h24, fix_ready=1: exactly two requests, (lane 2, value 0) then (lane 5, value 0). err_cnt=2 after the sweep; the sweep takes 9 cycles from SNAP to sweep_done.
- Same mismatch with fix_ready held low for 5 cycles: fix_lane=2 and fix_valid stay stable throughout, and the scan resumes only after acceptance.
- CNT_W=2 with a persistent single-lane mismatch: err_cnt goes 1, 2, 3, 3. clr_cnt asserted in the same cycle as an acceptance gives err_cnt=0.
- en dropped mid-SCAN at lane 3: the block reaches IDLE on the next edge with no sweep_done pulse. Re-enabling restarts at SNAP with lane 0.
- rstn=0 during REPORT with fix_ready=0: the next cycle shows fix_valid=0, busy=0, err_cnt=0 and the state is IDLE.

Source files
------------

// File: rtl/tmr_scrub_pkg.sv
// Shared definitions for the TMR lane scrubber: FSM encodings and small helpers.
package tmr_scrub_pkg;

    typedef logic [2:0] state_t;

    localparam state_t S_IDLE   = 3'd0;
    localparam state_t S_SNAP   = 3'd1;
    localparam state_t S_SCAN   = 3'd2;
    localparam state_t S_REPORT = 3'd3;
    localparam state_t S_WAIT   = 3'd4;

    // Index width that stays at least one bit wide for tiny ranges.
    function automatic int lane_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/tmr_scrub_wait_cnt.sv
// Inter-sweep idle counter: loads INTERVAL-1, counts down to zero and holds there.
module tmr_scrub_wait_cnt
    import tmr_scrub_pkg::*;
#(
    parameter int INTERVAL = 16
) (
    input  logic clk,
    input  logic rstn,
    input  logic load,
    input  logic dec,
    output logic zero
);

    localparam int CW = lane_w(INTERVAL);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= CW'(INTERVAL - 1);
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - CW'(1);
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/tmr_lane_scrubber.sv
// Walks a snapshot of three replica buses one lane per cycle and requests a
// majority-value refresh for every lane whose replicas disagree.
module tmr_lane_scrubber
    import tmr_scrub_pkg::*;
#(
    parameter int LANES    = 6,
    parameter int INTERVAL = 16,
    parameter int CNT_W    = 8
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     en,
    input  logic                     clr_cnt,
    input  logic [LANES-1:0]         in_a,
    input  logic [LANES-1:0]         in_b,
    input  logic [LANES-1:0]         in_c,
    output logic                     fix_valid,
    input  logic                     fix_ready,
    output logic [$clog2(LANES)-1:0] fix_lane,
    output logic                     fix_value,
    output logic                     sweep_done,
    output logic                     busy,
    output logic [CNT_W-1:0]         err_cnt
);

    localparam int LW = lane_w(LANES);

    state_t           state;
    logic [LANES-1:0] snap_a, snap_b, snap_c;
    logic [LW-1:0]    lane;

    logic cur_a, cur_b, cur_c;
    logic mism, last, accept, enter_wait, wait_zero;

    assign cur_a  = snap_a[lane];
    assign cur_b  = snap_b[lane];
    assign cur_c  = snap_c[lane];
    assign mism   = !((cur_a == cur_b) && (cur_b == cur_c));
    assign last   = (lane == LW'(LANES - 1));
    assign accept = fix_valid && fix_ready;

    // Finishing the last lane (clean or after its refresh) starts the idle gap.
    assign enter_wait = ((state == S_SCAN) && en && !mism && last) ||
                        ((state == S_REPORT) && accept && en && last);

    assign busy = (state == S_SNAP) || (state == S_SCAN) || (state == S_REPORT);

    tmr_scrub_wait_cnt #(
        .INTERVAL (INTERVAL)
    ) u_wait_cnt (
        .clk  (clk),
        .rstn (rstn),
        .load (enter_wait),
        .dec  (state == S_WAIT),
        .zero (wait_zero)
    );

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state      <= S_IDLE;
            snap_a     <= '0;
            snap_b     <= '0;
            snap_c     <= '0;
            lane       <= '0;
            fix_valid  <= 1'b0;
            fix_lane   <= '0;
            fix_value  <= 1'b0;
            sweep_done <= 1'b0;
            err_cnt    <= '0;
        end else begin
            sweep_done <= enter_wait;

            // A clear wins over a coincident increment.
            if (clr_cnt) begin
                err_cnt <= '0;
            end else if (accept && (err_cnt != '1)) begin
                err_cnt <= err_cnt + CNT_W'(1);
            end

            case (state)
                S_IDLE: begin
                    if (en) state <= S_SNAP;
                end
                S_SNAP: begin
                    snap_a <= in_a;
                    snap_b <= in_b;
                    snap_c <= in_c;
                    lane   <= '0;
                    state  <= S_SCAN;
                end
                S_SCAN: begin
                    if (!en) begin
                        state <= S_IDLE;
                    end else if (mism) begin
                        fix_lane  <= lane;
                        fix_value <= maj3(cur_a, cur_b, cur_c);
                        fix_valid <= 1'b1;
                        state     <= S_REPORT;
                    end else if (last) begin
                        state <= S_WAIT;
                    end else begin
                        lane <= lane + LW'(1);
                    end
                end
                S_REPORT: begin
                    if (accept) begin
                        fix_valid <= 1'b0;
                        if (!en) begin
                            state <= S_IDLE;
                        end else if (last) begin
                            state <= S_WAIT;
                        end else begin
                            lane  <= lane + LW'(1);
                            state <= S_SCAN;
                        end
                    end
                end
                S_WAIT: begin
                    if (wait_zero) state <= en ? S_SNAP : S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tmr_lane_scrubber.sv
// Directed bench for tmr_lane_scrubber: sweep timing, refresh handshake,
// counter saturation/clear, enable drop and reset during a request.
module tb_tmr_lane_scrubber;
    import tmr_scrub_pkg::*;

    logic       clk = 1'b0;
    logic       rstn, en, clr_cnt, clr_cnt2, fix_ready;
    logic [5:0] in_a, in_b, in_c;

    logic       fix_valid, fix_value, sweep_done, busy;
    logic [2:0] fix_lane;
    logic [7:0] err_cnt;

    logic       fix_valid2, fix_value2, sweep_done2, busy2;
    logic [2:0] fix_lane2;
    logic [1:0] err_cnt2;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    tmr_lane_scrubber #(.LANES(6), .INTERVAL(16), .CNT_W(8)) dut (
        .clk(clk), .rstn(rstn), .en(en), .clr_cnt(clr_cnt),
        .in_a(in_a), .in_b(in_b), .in_c(in_c),
        .fix_valid(fix_valid), .fix_ready(fix_ready), .fix_lane(fix_lane),
        .fix_value(fix_value), .sweep_done(sweep_done), .busy(busy), .err_cnt(err_cnt)
    );

    // Narrow counter and short gap so saturation is reached quickly.
    tmr_lane_scrubber #(.LANES(6), .INTERVAL(4), .CNT_W(2)) dut2 (
        .clk(clk), .rstn(rstn), .en(en), .clr_cnt(clr_cnt2),
        .in_a(in_a), .in_b(in_b), .in_c(in_c),
        .fix_valid(fix_valid2), .fix_ready(fix_ready), .fix_lane(fix_lane2),
        .fix_value(fix_value2), .sweep_done(sweep_done2), .busy(busy2), .err_cnt(err_cnt2)
    );

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic e, input logic [5:0] a, input logic [5:0] b,
                                 input logic [5:0] c, input logic rdy);
        en        = e;
        in_a      = a;
        in_b      = b;
        in_c      = c;
        fix_ready = rdy;
    endtask

    task automatic doReset();
        rstn     = 1'b0;
        clr_cnt  = 1'b0;
        clr_cnt2 = 1'b0;
        applyStimulus(1'b0, 6'h00, 6'h00, 6'h00, 1'b0);
        tick();
        tick();
        rstn = 1'b1;
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int         pulses[$];
        int         valid_seen;
        int         nreq;
        int         done_at;
        int         w;
        logic       stable;
        logic       any_done;
        logic [2:0] req_lane[2];
        logic       req_val[2];
        int         exp_sat[4];

        // Reset state
        doReset();
        checkOutput("rst_fix_valid",  32'(fix_valid), 0);
        checkOutput("rst_fix_lane",   32'(fix_lane), 0);
        checkOutput("rst_fix_value",  32'(fix_value), 0);
        checkOutput("rst_sweep_done", 32'(sweep_done), 0);
        checkOutput("rst_busy",       32'(busy), 0);
        checkOutput("rst_err_cnt",    32'(err_cnt), 0);

        // Clean replicas: periodic sweeps, no requests
        applyStimulus(1'b1, 6'h2A, 6'h2A, 6'h2A, 1'b0);
        valid_seen = 0;
        for (int i = 1; i <= 70; i++) begin
            tick();
            if (sweep_done) pulses.push_back(i);
            if (fix_valid) valid_seen++;
        end
        checkOutput("t1_pulse_count", 32'(pulses.size()), 3);
        if (pulses.size() == 3) begin
            checkOutput("t1_first_pulse", 32'(pulses[0]), 8);
            checkOutput("t1_period_a",    32'(pulses[1] - pulses[0]), 23);
            checkOutput("t1_period_b",    32'(pulses[2] - pulses[1]), 23);
        end
        checkOutput("t1_no_valid", 32'(valid_seen), 0);
        checkOutput("t1_err_cnt",  32'(err_cnt), 0);

        // Two mismatching lanes, ready held high
        doReset();
        applyStimulus(1'b1, 6'h00, 6'h00, 6'h24, 1'b1);
        nreq    = 0;
        done_at = 0;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (fix_valid && fix_ready) begin
                if (nreq < 2) begin
                    req_lane[nreq] = fix_lane;
                    req_val[nreq]  = fix_value;
                end
                nreq++;
            end
            if (sweep_done) begin
                done_at = i;
                checkOutput("t2_err_at_done", 32'(err_cnt), 2);
                break;
            end
        end
        checkOutput("t2_done_at", 32'(done_at), 10);
        checkOutput("t2_nreq", 32'(nreq), 2);
        if (nreq >= 2) begin
            checkOutput("t2_lane0",  32'(req_lane[0]), 2);
            checkOutput("t2_value0", 32'(req_val[0]), 0);
            checkOutput("t2_lane1",  32'(req_lane[1]), 5);
            checkOutput("t2_value1", 32'(req_val[1]), 0);
        end

        // Back-pressure: request must hold until accepted
        doReset();
        applyStimulus(1'b1, 6'h00, 6'h00, 6'h24, 1'b0);
        w = 0;
        while (!fix_valid && w < 20) begin
            tick();
            w++;
        end
        checkOutput("t3_valid_at", 32'(w), 5);
        stable = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            stable &= fix_valid && (fix_lane == 3'd2) && !fix_value && busy;
        end
        checkOutput("t3_hold_stable", 32'(stable), 1);
        checkOutput("t3_err_before", 32'(err_cnt), 0);
        fix_ready = 1'b1;
        tick();
        checkOutput("t3_valid_dropped", 32'(fix_valid), 0);
        checkOutput("t3_err_after", 32'(err_cnt), 1);
        tick();
        tick();
        checkOutput("t3_valid_gap", 32'(fix_valid), 0);
        tick();
        checkOutput("t3_next_valid", 32'(fix_valid), 1);
        checkOutput("t3_next_lane",  32'(fix_lane), 5);

        // Saturating 2-bit counter, then clear coincident with acceptance
        doReset();
        applyStimulus(1'b1, 6'h00, 6'h00, 6'h01, 1'b1);
        exp_sat = '{1, 2, 3, 3};
        for (int s = 0; s < 4; s++) begin
            w = 0;
            do begin
                tick();
                w++;
            end while (!sweep_done2 && w < 40);
            checkOutput($sformatf("t4_err_sweep%0d", s), 32'(err_cnt2), 32'(exp_sat[s]));
        end
        w = 0;
        while (!fix_valid2 && w < 40) begin
            tick();
            w++;
        end
        checkOutput("t4_valid_seen", 32'(fix_valid2), 1);
        clr_cnt2 = 1'b1;
        tick();
        clr_cnt2 = 1'b0;
        checkOutput("t4_clr_with_accept", 32'(err_cnt2), 0);
        checkOutput("t4_accepted", 32'(fix_valid2), 0);

        // Enable dropped while scanning lane 3
        doReset();
        applyStimulus(1'b1, 6'h2A, 6'h2A, 6'h2A, 1'b0);
        for (int k = 0; k < 5; k++) tick();
        checkOutput("t5_busy_scan", 32'(busy), 1);
        en = 1'b0;
        tick();
        checkOutput("t5_state_idle", 32'(dut.state), 32'(S_IDLE));
        checkOutput("t5_busy_off", 32'(busy), 0);
        any_done = sweep_done;
        for (int k = 0; k < 10; k++) begin
            tick();
            any_done |= sweep_done;
        end
        checkOutput("t5_no_sweep_done", 32'(any_done), 0);
        applyStimulus(1'b1, 6'h00, 6'h04, 6'h05, 1'b0);
        tick();
        checkOutput("t5_restart_snap", 32'(dut.state), 32'(S_SNAP));
        tick();
        tick();
        checkOutput("t5_valid_lane0", 32'(fix_valid), 1);
        checkOutput("t5_lane0",       32'(fix_lane), 0);
        checkOutput("t5_value0",      32'(fix_value), 0);

        // Reset while a request is pending
        fix_ready = 1'b1;
        tick();
        fix_ready = 1'b0;
        checkOutput("t6_err_one", 32'(err_cnt), 1);
        tick();
        tick();
        checkOutput("t6_valid_lane2", 32'(fix_valid), 1);
        checkOutput("t6_lane2",       32'(fix_lane), 2);
        checkOutput("t6_value2",      32'(fix_value), 1);
        rstn = 1'b0;
        tick();
        checkOutput("t6_rst_valid", 32'(fix_valid), 0);
        checkOutput("t6_rst_busy",  32'(busy), 0);
        checkOutput("t6_rst_err",   32'(err_cnt), 0);
        checkOutput("t6_rst_state", 32'(dut.state), 32'(S_IDLE));
        rstn = 1'b1;

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
